mult_norm_round: RTL
====================

MULT_NORM_ROUND -- requirements
Module: mult_norm_round

Interface
REQ-001 Parameter EXP_WIDTH, default 11, SHALL set the width of the biased result exponent.
REQ-002 Parameter MANT_WIDTH, default 52, SHALL set the width of the stored result fraction; the hidden bit is excluded.
REQ-003 Ports SHALL be as follows, with one clock and a synchronous, active-low reset:
- in_Clk  input  1  sole clock; all state updates on the rising edge.
- in_Rst_N  input  1  synchronous, active-low reset.
- in_Valid  input  1  upstream operand valid.
- out_Ready  output  1  block can accept an operand this cycle.
- in_Sign  input  1  product sign.
- in_Exp  input  EXP_WIDTH+2  two's-complement biased exponent sum (eA+eB-bias).
- in_Mant  input  2*MANT_WIDTH+2  raw significand product, 1.M x 1.M.
- out_Valid  output  1  result valid.
- in_Ready  input  1  downstream accepts the result.
- out_Sign  output  1  result sign.
- out_Exp  output  EXP_WIDTH  result biased exponent.
- out_Mant  output  MANT_WIDTH  result fraction.
- out_Overflow  output  1  result saturated to infinity.
- out_Underflow  output  1  result flushed to zero.
- out_Inexact  output  1  discarded bits were nonzero.

Function
REQ-004 The block SHALL be a 2-stage valid/ready pipeline: S1 normalises; S2 rounds, then checks range.
REQ-005 An input transfer SHALL occur on in_Valid&&out_Ready; an output transfer SHALL occur on out_Valid&&in_Ready.
REQ-006 out_Ready SHALL be high when S1 is empty, or when S1 advances this cycle; S1 advances when S2 is empty or is transferring.
REQ-007 Latency from input transfer to out_Valid SHALL be 2 cycles when unstalled; throughput SHALL be 1 result per cycle.
REQ-008 S1 normalisation SHALL depend on the product MSB (bit 2*MANT_WIDTH+1).
- MSB set: fraction = bits [2*MANT_WIDTH:MANT_WIDTH+1]; exponent += 1.
- MSB clear: fraction = bits [2*MANT_WIDTH-1:MANT_WIDTH]; exponent unchanged.
- S1 SHALL also capture a guard bit and a sticky bit (OR of all remaining lower bits).
REQ-009 S2 SHALL round to nearest, ties to even: increment when guard && (sticky || fraction LSB).
REQ-010 A rounding carry out of an all-ones fraction SHALL yield fraction 0 and exponent += 1.
REQ-011 out_Inexact SHALL equal guard || sticky.
REQ-012 Final exponent >= 2^EXP_WIDTH-1 SHALL produce out_Exp all ones, out_Mant 0 and out_Overflow=1; out_Inexact SHALL then be forced to 1.
REQ-013 Final exponent <= 0 SHALL produce out_Exp 0, out_Mant 0 and out_Underflow=1; denormals are not produced.
REQ-014 out_Sign SHALL pass through unchanged, including for saturated and flushed results.
REQ-015 While out_Valid=1 and in_Ready=0, all outputs SHALL hold stable.
REQ-016 Data SHALL never be dropped or duplicated; results SHALL leave in issue order.
REQ-017 NaN, infinity and zero operands are out of scope; the caller bypasses them.

Reset
REQ-018 While in_Rst_N=0 at a clock edge, both stage-valid flags SHALL clear.
- out_Valid, out_Overflow, out_Underflow and out_Inexact SHALL read 0.
- out_Sign, out_Exp and out_Mant SHALL read 0.
- out_Ready SHALL read 1 in the first cycle after reset.
REQ-019 Reset mid-operation SHALL discard in-flight results; no partial result may appear after reset.

Configuration
REQ-020 Macro MULT_NORM_ROUND_RNE_EN SHALL control rounding.
- Defined: rounding per REQ-009/010.
- Undefined: the fraction is truncated; out_Inexact is still computed; latency and handshake are unchanged.

Structure
REQ-021 A shared package SHALL hold the default EXP_WIDTH/MANT_WIDTH constants, the bias function (2^(EXP_WIDTH-1)-1) and the S1->S2 stage record typedef (sign, exponent, fraction, guard, sticky).
REQ-022 The S2 rounder SHALL be a sub-module named mult_round_rne.

Verification (double defaults)
REQ-023 in_Exp=1023, in_Mant=1<<104 (1.0x1.0) -> 2 cycles later: out_Exp=1023, out_Mant=0, all flags 0.
REQ-024 in_Exp=1023, in_Mant=(1<<105)|(1<<102) (1.5x1.5) -> out_Exp=1024, out_Mant=0x2000000000000, out_Inexact=0.
REQ-025 Tie cases:
- Fraction LSB 0, guard 1, sticky 0 -> fraction unchanged, out_Inexact=1.
- Fraction LSB 1, same guard/sticky -> fraction +1.
- All-ones fraction with guard 1 -> out_Mant=0, exponent +1.
REQ-026 Range cases:
- in_Exp=2046 with MSB set -> out_Exp=0x7FF, out_Mant=0, out_Overflow=1.
- in_Exp=0 with MSB clear -> zero result, out_Underflow=1.
REQ-027 Backpressure: 4 back-to-back inputs with in_Ready=0 for 5 cycles -> out_Ready low after 2 accepted; all 4 results emerge in order with stable outputs.
REQ-028 Reset mid-flight: assert in_Rst_N=0 with 2 results in flight -> out_Valid=0 next cycle; no stale result appears after release.

Source files
------------

// File: rtl/mult_norm_round_pkg.sv
// Shared constants, exponent bias helper and the normalise-to-round stage record
// for the mult_norm_round product normaliser/rounder.
package mult_norm_round_pkg;

    localparam int DEF_EXP_WIDTH  = 11;
    localparam int DEF_MANT_WIDTH = 52;

    // Exponent carried between stages needs sign plus two growth bits (normalise, round carry).
    localparam int REC_EXP_WIDTH  = DEF_EXP_WIDTH + 3;

    typedef struct packed {
        logic                      sign;
        logic [REC_EXP_WIDTH-1:0]  exp;
        logic [DEF_MANT_WIDTH-1:0] frac;
        logic                      guard;
        logic                      sticky;
    } s1_rec_t;

    function automatic int bias(input int exp_width);
        return (1 << (exp_width - 1)) - 1;
    endfunction

endpackage

// File: rtl/mult_round_rne.sv
// Second-stage rounder: round-to-nearest-even when MULT_NORM_ROUND_RNE_EN is defined,
// plain truncation otherwise. Inexact is reported in both builds.
module mult_round_rne
    import mult_norm_round_pkg::*;
#(
    parameter int EXP_WIDTH  = DEF_EXP_WIDTH,
    parameter int MANT_WIDTH = DEF_MANT_WIDTH
) (
    input  logic [MANT_WIDTH-1:0]  frac_in,
    input  logic                   guard,
    input  logic                   sticky,
    input  logic [EXP_WIDTH+2:0]   exp_in,
    output logic [MANT_WIDTH-1:0]  frac_out,
    output logic [EXP_WIDTH+2:0]   exp_out,
    output logic                   inexact
);

    logic                round_up;
    logic [MANT_WIDTH:0] frac_sum;

    always_comb begin
        round_up = 1'b0;
`ifdef MULT_NORM_ROUND_RNE_EN
        round_up = guard && (sticky || frac_in[0]);
`else
        round_up = 1'b0;
`endif
        frac_sum = {1'b0, frac_in} + {{MANT_WIDTH{1'b0}}, round_up};
        // A carry out of an all-ones fraction leaves fraction 0 and bumps the exponent.
        frac_out = frac_sum[MANT_WIDTH-1:0];
        exp_out  = exp_in + {{(EXP_WIDTH+2){1'b0}}, frac_sum[MANT_WIDTH]};
        inexact  = guard || sticky;
    end

endmodule

// File: rtl/mult_norm_round.sv
// Two-stage valid/ready pipeline: S1 normalises the raw significand product, S2 rounds
// (see MULT_NORM_ROUND_RNE_EN) then saturates to infinity or flushes to zero.
module mult_norm_round
    import mult_norm_round_pkg::*;
#(
    parameter int EXP_WIDTH  = DEF_EXP_WIDTH,
    parameter int MANT_WIDTH = DEF_MANT_WIDTH
) (
    input  logic                      in_Clk,
    input  logic                      in_Rst_N,
    input  logic                      in_Valid,
    output logic                      out_Ready,
    input  logic                      in_Sign,
    input  logic [EXP_WIDTH+1:0]      in_Exp,
    input  logic [2*MANT_WIDTH+1:0]   in_Mant,
    output logic                      out_Valid,
    input  logic                      in_Ready,
    output logic                      out_Sign,
    output logic [EXP_WIDTH-1:0]      out_Exp,
    output logic [MANT_WIDTH-1:0]     out_Mant,
    output logic                      out_Overflow,
    output logic                      out_Underflow,
    output logic                      out_Inexact
);

    localparam int PW = 2 * MANT_WIDTH + 2;
    localparam logic [EXP_WIDTH+2:0] EXP_MAX = {3'b000, {EXP_WIDTH{1'b1}}};

    logic                   s1_valid_q, s1_valid_d;
    s1_rec_t                s1_rec_q, s1_rec_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_sign_q, out_sign_d;
    logic [EXP_WIDTH-1:0]   out_exp_q, out_exp_d;
    logic [MANT_WIDTH-1:0]  out_mant_q, out_mant_d;
    logic                   out_ovf_q, out_ovf_d;
    logic                   out_unf_q, out_unf_d;
    logic                   out_inx_q, out_inx_d;

    logic                   s2_ready;
    logic                   s1_ready;
    logic                   msb;

    assign s2_ready  = !out_valid_q || in_Ready;
    assign s1_ready  = !s1_valid_q || s2_ready;
    assign out_Ready = s1_ready;
    assign msb       = in_Mant[PW-1];

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_rec_d   = s1_rec_q;
        if (s1_ready) begin
            s1_valid_d = in_Valid;
            if (in_Valid) begin
                s1_rec_d.sign = in_Sign;
                s1_rec_d.exp  = {in_Exp[EXP_WIDTH+1], in_Exp} + {{(EXP_WIDTH+2){1'b0}}, msb};
                if (msb) begin
                    s1_rec_d.frac   = in_Mant[2*MANT_WIDTH:MANT_WIDTH+1];
                    s1_rec_d.guard  = in_Mant[MANT_WIDTH];
                    s1_rec_d.sticky = |in_Mant[MANT_WIDTH-1:0];
                end else begin
                    s1_rec_d.frac   = in_Mant[2*MANT_WIDTH-1:MANT_WIDTH];
                    s1_rec_d.guard  = in_Mant[MANT_WIDTH-1];
                    s1_rec_d.sticky = |in_Mant[MANT_WIDTH-2:0];
                end
            end
        end
    end

    logic [MANT_WIDTH-1:0]  rnd_frac;
    logic [EXP_WIDTH+2:0]   rnd_exp;
    logic                   rnd_inexact;
    logic                   range_ovf;
    logic                   range_unf;

    mult_round_rne #(
        .EXP_WIDTH  (EXP_WIDTH),
        .MANT_WIDTH (MANT_WIDTH)
    ) u_round (
        .frac_in  (s1_rec_q.frac),
        .guard    (s1_rec_q.guard),
        .sticky   (s1_rec_q.sticky),
        .exp_in   (s1_rec_q.exp),
        .frac_out (rnd_frac),
        .exp_out  (rnd_exp),
        .inexact  (rnd_inexact)
    );

    // Range check runs on the rounded exponent, so a rounding carry can itself overflow.
    assign range_ovf = !rnd_exp[EXP_WIDTH+2] && (rnd_exp >= EXP_MAX);
    assign range_unf = rnd_exp[EXP_WIDTH+2] || (rnd_exp == '0);

    always_comb begin
        out_valid_d = out_valid_q;
        out_sign_d  = out_sign_q;
        out_exp_d   = out_exp_q;
        out_mant_d  = out_mant_q;
        out_ovf_d   = out_ovf_q;
        out_unf_d   = out_unf_q;
        out_inx_d   = out_inx_q;
        if (s2_ready) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_sign_d = s1_rec_q.sign;
                if (range_ovf) begin
                    out_exp_d  = '1;
                    out_mant_d = '0;
                    out_ovf_d  = 1'b1;
                    out_unf_d  = 1'b0;
                    out_inx_d  = 1'b1;
                end else if (range_unf) begin
                    out_exp_d  = '0;
                    out_mant_d = '0;
                    out_ovf_d  = 1'b0;
                    out_unf_d  = 1'b1;
                    out_inx_d  = rnd_inexact;
                end else begin
                    out_exp_d  = rnd_exp[EXP_WIDTH-1:0];
                    out_mant_d = rnd_frac;
                    out_ovf_d  = 1'b0;
                    out_unf_d  = 1'b0;
                    out_inx_d  = rnd_inexact;
                end
            end
        end
    end

    always_ff @(posedge in_Clk) begin
        if (!in_Rst_N) begin
            s1_valid_q  <= 1'b0;
            s1_rec_q    <= '0;
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_exp_q   <= '0;
            out_mant_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_unf_q   <= 1'b0;
            out_inx_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_rec_q    <= s1_rec_d;
            out_valid_q <= out_valid_d;
            out_sign_q  <= out_sign_d;
            out_exp_q   <= out_exp_d;
            out_mant_q  <= out_mant_d;
            out_ovf_q   <= out_ovf_d;
            out_unf_q   <= out_unf_d;
            out_inx_q   <= out_inx_d;
        end
    end

    assign out_Valid     = out_valid_q;
    assign out_Sign      = out_sign_q;
    assign out_Exp       = out_exp_q;
    assign out_Mant      = out_mant_q;
    assign out_Overflow  = out_ovf_q;
    assign out_Underflow = out_unf_q;
    assign out_Inexact   = out_inx_q;

endmodule
